// File: rtl/wb_write_port.sv
// wb_write_port: merges in-order pipeline results (port 0) and long-latency unit results
//   (port 1) onto the single register-file write port, and flags pending writes for decode.
// Latency: one cycle from accepted result to we/waddr/wdata (registered outputs).
// Backpressure: port 0 never stalls and has priority; port 1 is buffered in an in-order
//   FIFO of DEPTH entries and p1_ready drops when that FIFO is full.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   p0_valid/p0_addr/p0_data  pipeline result, always accepted
//   p1_valid/p1_ready         long-latency handshake (transfer on valid & ready)
//   p1_addr/p1_data           long-latency result
//   we/waddr/wdata            registered regfile write port
//   re1/raddr_1 -> hz_1       read port 1 snoop, pending-write flag
//   re2/raddr_2 -> hz_2       read port 2 snoop, pending-write flag
module wb_write_port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic              re1,
  output logic              hz_1,
  input  logic [ADDR_W-1:0] raddr_2,
  input  logic              re2,
  output logic              hz_2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Output register
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Per-cycle decisions
  logic p0_live, p1_take, p1_live, fifo_empty;
  logic pop, push, bypass;
  logic [DEPTH-1:0] ent_vld;
  logic hit_1, hit_2;

  // Ready depends on occupancy only; a same-cycle pop does not free a slot until next cycle.
  assign p1_ready = (count_q < CNT_W'(DEPTH));

  always_comb begin
    p0_live    = p0_valid & (p0_addr != '0);
    p1_take    = p1_valid & p1_ready;
    // Writes to $zero complete their handshake but are discarded here.
    p1_live    = p1_take & (p1_addr != '0);
    fifo_empty = (count_q == '0);

    pop    = ~p0_live & ~fifo_empty;
    // Empty FIFO and idle port 0: send p1 straight to the write register.
    bypass = ~p0_live & fifo_empty & p1_live;
    push   = p1_live & ~bypass;

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (p0_live) begin
      we_d    = 1'b1;
      waddr_d = p0_addr;
      wdata_d = p0_data;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = p1_addr;
      wdata_d = p1_data;
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

  // The output register counts as pending: its write lands at the next edge.
  always_comb begin
    hit_1 = we_q & (waddr_q == raddr_1);
    hit_2 = we_q & (waddr_q == raddr_2);
    for (int i = 0; i < DEPTH; i++) begin
      hit_1 = hit_1 | (ent_vld[i] & (fifo_addr_q[i] == raddr_1));
      hit_2 = hit_2 | (ent_vld[i] & (fifo_addr_q[i] == raddr_2));
    end
    hz_1 = re1 & (raddr_1 != '0) & hit_1;
    hz_2 = re2 & (raddr_2 != '0) & hit_2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= p1_addr;
        fifo_data_q[wr_ptr_q] <= p1_data;
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_write_port.sv
module tb_wb_write_port;

  logic        clk;
  logic        rst;
  logic        p0_valid;
  logic [4:0]  p0_addr;
  logic [31:0] p0_data;
  logic        p1_valid;
  logic        p1_ready;
  logic [4:0]  p1_addr;
  logic [31:0] p1_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_1;
  logic        re1;
  logic        hz_1;
  logic [4:0]  raddr_2;
  logic        re2;
  logic        hz_2;

  int checks   = 0;
  int failures = 0;

  wb_write_port #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_1(raddr_1), .re1(re1), .hz_1(hz_1),
    .raddr_2(raddr_2), .re2(re2), .hz_2(hz_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every regfile write as {addr, data}.
  logic        mon_en = 1'b0;
  logic [36:0] obs_q[$];
  always @(negedge clk) begin
    if (mon_en && we) obs_q.push_back({waddr, wdata});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
    p1_valid = 1'b0; p1_addr = '0; p1_data = '0;
    re1 = 1'b0; raddr_1 = '0; re2 = 1'b0; raddr_2 = '0;
  endtask

  // One row = inputs driven for a cycle and the outputs expected during that cycle
  // (registered outputs reflect earlier rows).
  typedef struct {
    logic p0v; logic [4:0] p0a; logic [31:0] p0d;
    logic p1v; logic [4:0] p1a; logic [31:0] p1d;
    logic re1; logic [4:0] ra1; logic re2; logic [4:0] ra2;
    logic ewe; logic [4:0] ewa; logic [31:0] ewd;
    logic erdy; logic ehz1; logic ehz2;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  logic [36:0] exp_all[$];
  logic [36:0] exp0_q[$];
  logic [36:0] exp1_q[$];
  logic [36:0] obs0_q[$];
  logic [36:0] obs1_q[$];
  int p1_idx;
  logic take;
  logic saw_full;
  logic p0_on;

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("reset_we", we, 0);
    chk("reset_rdy", p1_ready, 1);
    #11 rst = 1'b0;

    //        p0v p0a  p0d           p1v p1a  p1d        re1 ra1  re2 ra2  we  wa   wd            rdy hz1 hz2
    tbl[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0,        1, 0, 0};
    tbl[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 5'd5, 0, 5'd0, 0, 5'd0, 32'h0,        1, 0, 0};
    tbl[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd5, 1, 5'd0, 1, 5'd5, 32'hDEADBEEF, 1, 1, 0};
    tbl[3]  = '{1, 5'd3, 32'h3,        1, 5'd7, 32'h77,   1, 5'd7, 0, 5'd0, 0, 5'd5, 32'hDEADBEEF, 1, 0, 0};
    tbl[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 1, 5'd3, 1, 5'd3, 32'h3,        1, 1, 1};
    tbl[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 1, 5'd3, 1, 5'd7, 32'h77,       1, 1, 0};
    tbl[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 0, 5'd0, 0, 5'd7, 32'h77,       1, 0, 0};
    tbl[7]  = '{1, 5'd0, 32'h1234,     1, 5'd0, 32'h55,   1, 5'd0, 1, 5'd0, 0, 5'd7, 32'h77,       1, 0, 0};
    tbl[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd0, 0, 5'd0, 0, 5'd7, 32'h77,       1, 0, 0};
    tbl[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd0, 0, 5'd0, 0, 5'd7, 32'h77,       1, 0, 0};
    tbl[10] = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h99,   1, 5'd9, 0, 5'd0, 0, 5'd7, 32'h77,       1, 0, 0};
    tbl[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd9, 0, 5'd0, 1, 5'd9, 32'h99,       1, 1, 0};
    tbl[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd9, 1, 5'd9, 0, 5'd9, 32'h99,       1, 0, 0};

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      p0_valid = tbl[r].p0v; p0_addr = tbl[r].p0a; p0_data = tbl[r].p0d;
      p1_valid = tbl[r].p1v; p1_addr = tbl[r].p1a; p1_data = tbl[r].p1d;
      re1 = tbl[r].re1; raddr_1 = tbl[r].ra1; re2 = tbl[r].re2; raddr_2 = tbl[r].ra2;
      #1;
      chk($sformatf("row%0d_we", r),    we,       tbl[r].ewe);
      chk($sformatf("row%0d_waddr", r), waddr,    tbl[r].ewa);
      chk($sformatf("row%0d_wdata", r), wdata,    tbl[r].ewd);
      chk($sformatf("row%0d_rdy", r),   p1_ready, tbl[r].erdy);
      chk($sformatf("row%0d_hz1", r),   hz_1,     tbl[r].ehz1);
      chk($sformatf("row%0d_hz2", r),   hz_2,     tbl[r].ehz2);
    end

    // Port 0 busy 8 cycles while port 1 offers r10..r15.
    @(negedge clk);
    idle_inputs();
    obs_q.delete();
    mon_en = 1'b1;
    p1_idx = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      p0_valid = (c < 8); p0_addr = 5'(c + 1); p0_data = 32'hA000_0000 + 32'(c);
      p1_valid = (p1_idx < 6); p1_addr = 5'(10 + p1_idx); p1_data = 32'hB000_0000 + 32'(p1_idx);
      re1 = 1'b1; raddr_1 = 5'd12; re2 = 1'b1; raddr_2 = 5'd14;
      #1;
      if (c == 6) begin
        chk("t4_ready_low", p1_ready, 0);
        chk("t4_accepted", p1_idx, 4);
        chk("t4_hz_queued", hz_1, 1);
        chk("t4_hz_not_yet", hz_2, 0);
      end
      take = p1_valid & p1_ready;
      @(posedge clk);
      if (take) p1_idx++;
    end
    @(negedge clk);
    idle_inputs();
    re1 = 1'b1; raddr_1 = 5'd12; re2 = 1'b1; raddr_2 = 5'd14;
    #1;
    chk("t4_hz_stale1", hz_1, 0);
    chk("t4_hz_stale2", hz_2, 0);
    chk("t4_all_taken", p1_idx, 6);
    exp_all.delete();
    for (int i = 0; i < 8; i++) exp_all.push_back({5'(i + 1), 32'hA000_0000 + 32'(i)});
    for (int i = 0; i < 6; i++) exp_all.push_back({5'(10 + i), 32'hB000_0000 + 32'(i)});
    chk("t4_nwrites", obs_q.size(), exp_all.size());
    for (int i = 0; i < exp_all.size() && i < obs_q.size(); i++)
      chk($sformatf("t4_write%0d", i), obs_q[i], exp_all[i]);

    // Back-to-back port 1 burst against intermittent port 0 traffic.
    obs_q.delete();
    exp0_q.delete();
    exp1_q.delete();
    p1_idx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 200 && p1_idx < 12; c++) begin
      @(negedge clk);
      p0_on = (c < 5) || (c % 4 == 1);
      p0_valid = p0_on; p0_addr = 5'(1 + c % 8); p0_data = 32'hE000_0000 + 32'(c);
      p1_valid = 1'b1; p1_addr = 5'(16 + p1_idx); p1_data = 32'hC0DE_0000 + 32'(p1_idx);
      #1;
      if (!p1_ready) saw_full = 1'b1;
      if (p0_on) exp0_q.push_back({p0_addr, p0_data});
      take = p1_valid & p1_ready;
      if (take) exp1_q.push_back({p1_addr, p1_data});
      @(posedge clk);
      if (take) p1_idx++;
    end
    @(negedge clk);
    idle_inputs();
    repeat (12) @(negedge clk);
    chk("t6_all_taken", p1_idx, 12);
    chk("t6_saw_full", saw_full, 1);
    obs0_q.delete();
    obs1_q.delete();
    foreach (obs_q[i]) begin
      if (obs_q[i][36:32] >= 5'd16) obs1_q.push_back(obs_q[i]);
      else obs0_q.push_back(obs_q[i]);
    end
    chk("t6_n_p0", obs0_q.size(), exp0_q.size());
    chk("t6_n_p1", obs1_q.size(), exp1_q.size());
    for (int i = 0; i < exp0_q.size() && i < obs0_q.size(); i++)
      chk($sformatf("t6_p0_%0d", i), obs0_q[i], exp0_q[i]);
    for (int i = 0; i < exp1_q.size() && i < obs1_q.size(); i++)
      chk($sformatf("t6_p1_%0d", i), obs1_q[i], exp1_q[i]);

    // Async reset mid-cycle with two entries queued.
    mon_en = 1'b0;
    @(negedge clk);
    p0_valid = 1'b1; p0_addr = 5'd1; p0_data = 32'h1;
    p1_valid = 1'b1; p1_addr = 5'd20; p1_data = 32'h20;
    @(negedge clk);
    p0_addr = 5'd2; p0_data = 32'h2;
    p1_addr = 5'd21; p1_data = 32'h21;
    @(negedge clk);
    p0_addr = 5'd3; p0_data = 32'h3;
    p1_valid = 1'b0;
    re1 = 1'b1; raddr_1 = 5'd20;
    #1;
    chk("t1_pre_hz", hz_1, 1);
    chk("t1_pre_we", we, 1);
    #1 rst = 1'b1;
    #1;
    chk("t1_we", we, 0);
    chk("t1_waddr", waddr, 0);
    chk("t1_wdata", wdata, 0);
    chk("t1_rdy", p1_ready, 1);
    chk("t1_hz", hz_1, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    obs_q.delete();
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1_no_writes", obs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
